frame_update_scheduler: RTL

- Sequences per-frame game-logic updates for the TinyTapeStation top level: player, dragon, sheep and collision units.
- On each vertical-blank start pulse, it issues a one-cycle start request to each enabled update unit in fixed priority order (index 0 first). It waits for that unit's done before moving to the next.
- It guarantees the units never run concurrently, so they can share the object-position registers.
- A per-unit watchdog stops a hung unit from stalling the frame. Frame overruns are flagged.

---
 rtl/frame_update_scheduler.sv | 111 +++++++++++
 1 files changed

// File: rtl/frame_update_scheduler.sv
// rtl/frame_update_scheduler.sv - per-frame sequencer for game-logic update units
// Issues one start pulse per enabled unit in index order, with a per-unit watchdog.
module frame_update_scheduler #(
   parameter int N_UNITS = 4,
   parameter int TIMEOUT = 200,
   parameter int TW      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic [N_UNITS-1:0] unit_en,
   input  logic [N_UNITS-1:0] unit_done,
   output logic [N_UNITS-1:0] start_req,
   output logic [2:0]         cur_unit,
   output logic               busy,
   output logic               frame_done,
   output logic               frame_overrun,
   output logic [N_UNITS-1:0] timeout_err,
   output logic [7:0]         frame_count
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

   state_t             state;
   logic [N_UNITS-1:0] pending;
   logic [N_UNITS-1:0] cur_mask;
   logic [TW-1:0]      wd;
   logic               cur_done;

   function automatic logic [N_UNITS-1:0] lowest_onehot(input logic [N_UNITS-1:0] v);
      return v & (~v + N_UNITS'(1));
   endfunction

   function automatic logic [2:0] lowest_index(input logic [N_UNITS-1:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = N_UNITS - 1; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // cur_mask tracks the awaited unit as a one-hot, so stray done bits drop out here
   assign cur_done = |(unit_done & cur_mask);
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         pending       <= '0;
         cur_mask      <= '0;
         wd            <= '0;
         start_req     <= '0;
         cur_unit      <= '0;
         frame_done    <= 1'b0;
         frame_overrun <= 1'b0;
         timeout_err   <= '0;
         frame_count   <= '0;
      end else begin
         start_req     <= '0;
         frame_done    <= 1'b0;
         frame_overrun <= frame_start && (state != S_IDLE);
         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  pending     <= unit_en;
                  timeout_err <= '0;
                  if (unit_en == '0) begin
                     frame_done <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     cur_unit  <= lowest_index(unit_en);
                     cur_mask  <= lowest_onehot(unit_en);
                     start_req <= lowest_onehot(unit_en);
                     state     <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               pending <= pending & ~cur_mask;
               wd      <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               wd <= wd + TW'(1);
               if (cur_done || (wd == WD_LAST)) begin
                  // Done on the expiry cycle still counts as a clean completion
                  if (!cur_done) timeout_err <= timeout_err | cur_mask;
                  if (pending != '0) begin
                     cur_unit  <= lowest_index(pending);
                     cur_mask  <= lowest_onehot(pending);
                     start_req <= lowest_onehot(pending);
                     state     <= S_ISSUE;
                  end else begin
                     frame_done <= 1'b1;
                     state      <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               frame_count <= frame_count + 8'd1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
